// File: rtl/dmem_arbiter.sv
// dmem_arbiter
// Two-requester arbiter in front of a single-ported data memory.
// Ownership is round-robin when idle. A requester can hold the memory with
// a lock, but after MAX_BURST consecutive locked accesses it must give way
// to a waiting peer for one access.
//
// Ports
//   clk, rst                 clock, synchronous active-high reset
//   mX_req/we/addr/wdata     access request from requester X (0 or 1)
//   mX_lock                  keep ownership after this access
//   mX_gnt                   access accepted this cycle (combinational)
//   mX_rvalid, mX_rdata      one-cycle read-data pulse, registered read data
//   mem_we/mem_a/mem_wd      memory write enable, address, write data
//   mem_rd                   memory combinational read data
module dmem_arbiter #(
  parameter int DW        = 32,
  parameter int MAX_BURST = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          m0_req,
  input  logic          m0_we,
  input  logic [31:0]   m0_addr,
  input  logic [DW-1:0] m0_wdata,
  input  logic          m0_lock,
  input  logic          m1_req,
  input  logic          m1_we,
  input  logic [31:0]   m1_addr,
  input  logic [DW-1:0] m1_wdata,
  input  logic          m1_lock,
  output logic          m0_gnt,
  output logic          m1_gnt,
  output logic          m0_rvalid,
  output logic          m1_rvalid,
  output logic [DW-1:0] m0_rdata,
  output logic [DW-1:0] m1_rdata,
  output logic          mem_we,
  output logic [31:0]   mem_a,
  output logic [DW-1:0] mem_wd,
  input  logic [DW-1:0] mem_rd
);

  typedef enum logic [1:0] {IDLE, LOCK0, LOCK1} state_e;

  localparam logic [7:0] MaxCnt = 8'(MAX_BURST);

  state_e        state_q, state_d;
  logic          lastGnt_q, lastGnt_d;
  logic [7:0]    burstCnt_q, burstCnt_d;
  logic          rValid0_q, rValid1_q;
  logic [DW-1:0] rData0_q, rData1_q;
  logic          gnt0, gnt1;

  // Grant selection and next-state logic. The grant is decided first from
  // the current state; the next state then follows from whoever was granted,
  // which keeps lock entry, burst counting and fairness hand-over in one place.
  always_comb begin
    gnt0       = 1'b0;
    gnt1       = 1'b0;
    state_d    = state_q;
    lastGnt_d  = lastGnt_q;
    burstCnt_d = burstCnt_q;

    case (state_q)
      IDLE: begin
        // On contention the requester that did not go last wins.
        if (m0_req && m1_req) begin
          if (lastGnt_q) gnt0 = 1'b1;
          else           gnt1 = 1'b1;
        end else begin
          gnt0 = m0_req;
          gnt1 = m1_req;
        end
      end
      LOCK0: begin
        // Burst limit reached and the peer is waiting: peer goes first.
        if (burstCnt_q == MaxCnt && m1_req) gnt1 = 1'b1;
        else                                gnt0 = m0_req;
      end
      LOCK1: begin
        if (burstCnt_q == MaxCnt && m0_req) gnt0 = 1'b1;
        else                                gnt1 = m1_req;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (rst) begin
      gnt0 = 1'b0;
      gnt1 = 1'b0;
    end

    if (gnt0) begin
      lastGnt_d = 1'b0;
      if (m0_lock) begin
        state_d = LOCK0;
        // Counting continues only inside an existing LOCK0 burst; a fresh
        // lock (from IDLE or taken over from LOCK1) starts at one.
        if (state_q == LOCK0)
          burstCnt_d = (burstCnt_q == MaxCnt) ? MaxCnt : burstCnt_q + 8'd1;
        else
          burstCnt_d = 8'd1;
      end else begin
        state_d    = IDLE;
        burstCnt_d = 8'd0;
      end
    end else if (gnt1) begin
      lastGnt_d = 1'b1;
      if (m1_lock) begin
        state_d = LOCK1;
        if (state_q == LOCK1)
          burstCnt_d = (burstCnt_q == MaxCnt) ? MaxCnt : burstCnt_q + 8'd1;
        else
          burstCnt_d = 8'd1;
      end else begin
        state_d    = IDLE;
        burstCnt_d = 8'd0;
      end
    end else if (state_q != IDLE) begin
      // The owner dropped its request, so the lock is released.
      state_d    = IDLE;
      burstCnt_d = 8'd0;
    end
  end

  // Memory-side mux: the granted requester drives the memory, otherwise
  // everything is held at zero.
  always_comb begin
    mem_we = (gnt0 & m0_we) | (gnt1 & m1_we);
    mem_a  = 32'd0;
    mem_wd = '0;
    if (gnt0) begin
      mem_a  = m0_addr;
      mem_wd = m0_wdata;
    end else if (gnt1) begin
      mem_a  = m1_addr;
      mem_wd = m1_wdata;
    end
  end

  assign m0_gnt   = gnt0;
  assign m1_gnt   = gnt1;
  // A pulse from a read accepted just before reset must not leak out
  // while reset is held.
  assign m0_rvalid = rValid0_q & ~rst;
  assign m1_rvalid = rValid1_q & ~rst;
  assign m0_rdata  = rData0_q;
  assign m1_rdata  = rData1_q;

  // State, arbitration history and read-return registers. Read data is
  // captured on the accept edge and held until the same requester reads again.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      lastGnt_q  <= 1'b1;
      burstCnt_q <= 8'd0;
      rValid0_q  <= 1'b0;
      rValid1_q  <= 1'b0;
      rData0_q   <= '0;
      rData1_q   <= '0;
    end else begin
      state_q    <= state_d;
      lastGnt_q  <= lastGnt_d;
      burstCnt_q <= burstCnt_d;
      rValid0_q  <= gnt0 & ~m0_we;
      rValid1_q  <= gnt1 & ~m1_we;
      if (gnt0 && !m0_we) rData0_q <= mem_rd;
      if (gnt1 && !m1_we) rData1_q <= mem_rd;
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter
// Self-checking bench for dmem_arbiter with a small behavioural memory.
// Expected read data is queued when a read is issued and compared when the
// read-valid pulse is due.
module tb_dmem_arbiter;

  localparam int DW        = 32;
  localparam int MAX_BURST = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          m0Req, m0We, m0Lock, m1Req, m1We, m1Lock;
  logic [31:0]   m0Addr, m1Addr;
  logic [DW-1:0] m0Wdata, m1Wdata;
  logic          m0Gnt, m1Gnt, m0Rvalid, m1Rvalid;
  logic [DW-1:0] m0Rdata, m1Rdata;
  logic          memWe;
  logic [31:0]   memA;
  logic [DW-1:0] memWd, memRd;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  typedef struct {
    logic [DW-1:0] data;
    int            due;
  } rdExp_t;

  rdExp_t        exp0Q[$];
  rdExp_t        exp1Q[$];
  logic [DW-1:0] mem    [64];
  logic [DW-1:0] expMem [64];
  logic          memReady = 1'b0;

  dmem_arbiter #(.DW(DW), .MAX_BURST(MAX_BURST)) dut (
    .clk(clk), .rst(rst),
    .m0_req(m0Req), .m0_we(m0We), .m0_addr(m0Addr), .m0_wdata(m0Wdata), .m0_lock(m0Lock),
    .m1_req(m1Req), .m1_we(m1We), .m1_addr(m1Addr), .m1_wdata(m1Wdata), .m1_lock(m1Lock),
    .m0_gnt(m0Gnt), .m1_gnt(m1Gnt),
    .m0_rvalid(m0Rvalid), .m1_rvalid(m1Rvalid),
    .m0_rdata(m0Rdata), .m1_rdata(m1Rdata),
    .mem_we(memWe), .mem_a(memA), .mem_wd(memWd), .mem_rd(memRd)
  );

  always #5 clk = ~clk;

  // Free-running cycle count used to time expected read-valid pulses.
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [DW-1:0] initWord(input int i);
    if (i == 5) return 32'h0000_0002;
    return 32'h1000_0000 + i;
  endfunction

  // Behavioural memory: filled on the first edge, then written by the DUT.
  always @(posedge clk) begin
    if (!memReady) begin
      for (int i = 0; i < 64; i++) mem[i] <= initWord(i);
      memReady <= 1'b1;
    end else if (memWe && memA < 32'd64) begin
      mem[memA[5:0]] <= memWd;
    end
  end

  assign memRd = (memA < 32'd64) ? mem[memA[5:0]] : '0;

  // Scoreboard side: every due read must show rvalid with the queued data,
  // and any rvalid without a due entry is spurious.
  always @(negedge clk) begin
    if (exp0Q.size() != 0 && exp0Q[0].due == cyc) begin
      checks++;
      if (m0Rvalid !== 1'b1 || m0Rdata !== exp0Q[0].data) begin
        failures++;
        $display("[TB] FAIL m0_read rvalid=%0b rdata=%h want rvalid=1 rdata=%h", m0Rvalid, m0Rdata, exp0Q[0].data);
      end
      void'(exp0Q.pop_front());
    end else if (m0Rvalid !== 1'b0) begin
      checks++;
      failures++;
      $display("[TB] FAIL m0_rvalid_spurious got=%0b want=0", m0Rvalid);
    end
    if (exp1Q.size() != 0 && exp1Q[0].due == cyc) begin
      checks++;
      if (m1Rvalid !== 1'b1 || m1Rdata !== exp1Q[0].data) begin
        failures++;
        $display("[TB] FAIL m1_read rvalid=%0b rdata=%h want rvalid=1 rdata=%h", m1Rvalid, m1Rdata, exp1Q[0].data);
      end
      void'(exp1Q.pop_front());
    end else if (m1Rvalid !== 1'b0) begin
      checks++;
      failures++;
      $display("[TB] FAIL m1_rvalid_spurious got=%0b want=0", m1Rvalid);
    end
  end

  task automatic setM0(input logic req, input logic we, input logic lock,
                       input logic [31:0] addr, input logic [DW-1:0] wdata);
    m0Req = req; m0We = we; m0Lock = lock; m0Addr = addr; m0Wdata = wdata;
  endtask

  task automatic setM1(input logic req, input logic we, input logic lock,
                       input logic [31:0] addr, input logic [DW-1:0] wdata);
    m1Req = req; m1We = we; m1Lock = lock; m1Addr = addr; m1Wdata = wdata;
  endtask

  task automatic idleAll();
    setM0(1'b0, 1'b0, 1'b0, 32'd0, '0);
    setM1(1'b0, 1'b0, 1'b0, 32'd0, '0);
  endtask

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic doReset();
    rst = 1'b1;
    idleAll();
    nextCycle();
    rst = 1'b0;
  endtask

  // Outputs held quiet while reset is asserted, then idle outputs at zero.
  task automatic test_reset();
    setM0(1'b1, 1'b1, 1'b0, 32'd5, 32'h0000_00AA);
    setM1(1'b1, 1'b1, 1'b0, 32'd6, 32'h0000_00BB);
    @(negedge clk);
    checks++;
    if (m0Gnt !== 1'b0 || m1Gnt !== 1'b0 || memWe !== 1'b0) begin
      failures++;
      $display("[TB] FAIL reset_gnt got gnt0=%0b gnt1=%0b we=%0b want 0 0 0", m0Gnt, m1Gnt, memWe);
    end
    checks++;
    if (m0Rdata !== '0 || m1Rdata !== '0) begin
      failures++;
      $display("[TB] FAIL reset_rdata got %h %h want 0 0", m0Rdata, m1Rdata);
    end
    nextCycle();
    rst = 1'b0;
    idleAll();
    setM0(1'b0, 1'b1, 1'b0, 32'd9, 32'h1234_5678);
    @(negedge clk);
    checks++;
    if (memA !== 32'd0 || memWd !== '0 || memWe !== 1'b0 || m0Gnt !== 1'b0) begin
      failures++;
      $display("[TB] FAIL idle_mem got a=%h wd=%h we=%0b gnt0=%0b want 0 0 0 0", memA, memWd, memWe, m0Gnt);
    end
    nextCycle();
  endtask

  task automatic test_single_read();
    doReset();
    idleAll();
    setM0(1'b1, 1'b0, 1'b0, 32'd5, '0);
    @(negedge clk);
    checks++;
    if (m0Gnt !== 1'b1 || m1Gnt !== 1'b0 || memA !== 32'd5 || memWe !== 1'b0) begin
      failures++;
      $display("[TB] FAIL single_read_gnt got gnt0=%0b gnt1=%0b a=%h we=%0b want 1 0 5 0", m0Gnt, m1Gnt, memA, memWe);
    end
    exp0Q.push_back('{data: expMem[5], due: cyc + 1});
    nextCycle();
    idleAll();
    @(negedge clk);
    checks++;
    if (m0Rdata !== 32'h0000_0002) begin
      failures++;
      $display("[TB] FAIL single_read_data got=%h want=00000002", m0Rdata);
    end
    nextCycle();
    @(negedge clk);
    checks++;
    if (m0Rvalid !== 1'b0 || m0Rdata !== 32'h0000_0002) begin
      failures++;
      $display("[TB] FAIL rdata_hold got rvalid=%0b rdata=%h want 0 00000002", m0Rvalid, m0Rdata);
    end
    nextCycle();
  endtask

  // Continuous contention without lock alternates m0, m1, m0, m1.
  task automatic test_round_robin();
    doReset();
    for (int k = 0; k < 4; k++) begin
      logic          expM0;
      logic [31:0]   expA;
      logic [DW-1:0] expWd;
      setM0(1'b1, 1'b1, 1'b0, 32'(10 + k), 32'hC0DE_0000 + k);
      setM1(1'b1, 1'b0, 1'b0, 32'(20 + k), 32'hAAAA_0000 + k);
      expM0 = (k % 2 == 0);
      expA  = expM0 ? 32'(10 + k) : 32'(20 + k);
      expWd = expM0 ? 32'hC0DE_0000 + k : 32'hAAAA_0000 + k;
      @(negedge clk);
      checks++;
      if (m0Gnt !== expM0 || m1Gnt !== !expM0 || memWe !== expM0) begin
        failures++;
        $display("[TB] FAIL rr_gnt[%0d] got gnt0=%0b gnt1=%0b we=%0b want %0b %0b %0b", k, m0Gnt, m1Gnt, memWe, expM0, !expM0, expM0);
      end
      checks++;
      if (memA !== expA || memWd !== expWd) begin
        failures++;
        $display("[TB] FAIL rr_bus[%0d] got a=%h wd=%h want a=%h wd=%h", k, memA, memWd, expA, expWd);
      end
      if (expM0) expMem[10 + k] = 32'hC0DE_0000 + k;
      else       exp1Q.push_back('{data: expMem[20 + k], due: cyc + 1});
      nextCycle();
    end
    idleAll();
    nextCycle();
  endtask

  task automatic test_write_then_read();
    idleAll();
    setM1(1'b1, 1'b1, 1'b0, 32'd6, 32'hDEAD_BEEF);
    @(negedge clk);
    checks++;
    if (m1Gnt !== 1'b1 || m0Gnt !== 1'b0 || memWe !== 1'b1 || memA !== 32'd6 || memWd !== 32'hDEAD_BEEF) begin
      failures++;
      $display("[TB] FAIL wr_m1 got gnt1=%0b gnt0=%0b we=%0b a=%h wd=%h want 1 0 1 6 deadbeef", m1Gnt, m0Gnt, memWe, memA, memWd);
    end
    expMem[6] = 32'hDEAD_BEEF;
    nextCycle();
    idleAll();
    setM0(1'b1, 1'b0, 1'b0, 32'd6, '0);
    @(negedge clk);
    checks++;
    if (m0Gnt !== 1'b1 || memWe !== 1'b0 || memA !== 32'd6) begin
      failures++;
      $display("[TB] FAIL rd_m0 got gnt0=%0b we=%0b a=%h want 1 0 6", m0Gnt, memWe, memA);
    end
    exp0Q.push_back('{data: expMem[6], due: cyc + 1});
    nextCycle();
    idleAll();
    @(negedge clk);
    checks++;
    if (m0Rdata !== 32'hDEAD_BEEF) begin
      failures++;
      $display("[TB] FAIL wr_rd_data got=%h want=deadbeef", m0Rdata);
    end
    nextCycle();
  endtask

  // m0 locks for 12 reads, m1 waits from cycle 2: m0 x8, m1 once, then m0.
  task automatic test_lock_burst();
    int m0Cnt;
    m0Cnt = 0;
    doReset();
    for (int c = 1; c <= 13; c++) begin
      logic expM0, expM1;
      setM0(m0Cnt < 12, 1'b0, 1'b1, 32'(30 + m0Cnt), '0);
      setM1(c >= 2, 1'b1, 1'b0, 32'd50, 32'(c));
      expM1 = (c == 9);
      expM0 = !expM1;
      @(negedge clk);
      checks++;
      if (m0Gnt !== expM0 || m1Gnt !== expM1 || memWe !== expM1) begin
        failures++;
        $display("[TB] FAIL lock_gnt[%0d] got gnt0=%0b gnt1=%0b we=%0b want %0b %0b %0b", c, m0Gnt, m1Gnt, memWe, expM0, expM1, expM1);
      end
      if (expM0) begin
        exp0Q.push_back('{data: expMem[30 + m0Cnt], due: cyc + 1});
        m0Cnt++;
      end
      if (expM1) expMem[50] = 32'(c);
      nextCycle();
    end
    idleAll();
    @(negedge clk);
    checks++;
    if (m0Gnt !== 1'b0 || m1Gnt !== 1'b0) begin
      failures++;
      $display("[TB] FAIL lock_end got gnt0=%0b gnt1=%0b want 0 0", m0Gnt, m1Gnt);
    end
    nextCycle();
  endtask

  // Owner drops its request mid-burst: nobody granted, then the peer wins.
  task automatic test_lock_drop();
    doReset();
    for (int k = 0; k < 3; k++) begin
      setM0(1'b1, 1'b0, 1'b1, 32'(40 + k), '0);
      @(negedge clk);
      checks++;
      if (m0Gnt !== 1'b1 || m1Gnt !== 1'b0) begin
        failures++;
        $display("[TB] FAIL drop_burst[%0d] got gnt0=%0b gnt1=%0b want 1 0", k, m0Gnt, m1Gnt);
      end
      exp0Q.push_back('{data: expMem[40 + k], due: cyc + 1});
      nextCycle();
    end
    setM0(1'b0, 1'b0, 1'b0, 32'd0, '0);
    setM1(1'b1, 1'b0, 1'b0, 32'd7, '0);
    @(negedge clk);
    checks++;
    if (m0Gnt !== 1'b0 || m1Gnt !== 1'b0 || memA !== 32'd0) begin
      failures++;
      $display("[TB] FAIL drop_gap got gnt0=%0b gnt1=%0b a=%h want 0 0 0", m0Gnt, m1Gnt, memA);
    end
    nextCycle();
    @(negedge clk);
    checks++;
    if (m1Gnt !== 1'b1 || m0Gnt !== 1'b0 || memA !== 32'd7) begin
      failures++;
      $display("[TB] FAIL drop_peer got gnt1=%0b gnt0=%0b a=%h want 1 0 7", m1Gnt, m0Gnt, memA);
    end
    exp1Q.push_back('{data: expMem[7], due: cyc + 1});
    nextCycle();
    idleAll();
    nextCycle();
  endtask

  // Reset right after an m1 read accept cancels the pending pulse.
  task automatic test_reset_after_read();
    doReset();
    setM1(1'b1, 1'b0, 1'b0, 32'd8, '0);
    @(negedge clk);
    checks++;
    if (m1Gnt !== 1'b1) begin
      failures++;
      $display("[TB] FAIL rst_rd_accept got gnt1=%0b want 1", m1Gnt);
    end
    nextCycle();
    rst = 1'b1;
    idleAll();
    @(negedge clk);
    checks++;
    if (m1Rvalid !== 1'b0 || m1Gnt !== 1'b0) begin
      failures++;
      $display("[TB] FAIL rst_rvalid_during got rvalid=%0b gnt1=%0b want 0 0", m1Rvalid, m1Gnt);
    end
    nextCycle();
    rst = 1'b0;
    setM0(1'b1, 1'b0, 1'b0, 32'd9, '0);
    setM1(1'b1, 1'b0, 1'b0, 32'd11, '0);
    @(negedge clk);
    checks++;
    if (m1Rvalid !== 1'b0 || m1Rdata !== '0) begin
      failures++;
      $display("[TB] FAIL rst_rd_after got rvalid=%0b rdata=%h want 0 0", m1Rvalid, m1Rdata);
    end
    checks++;
    if (m0Gnt !== 1'b1 || m1Gnt !== 1'b0) begin
      failures++;
      $display("[TB] FAIL rst_idle_contend got gnt0=%0b gnt1=%0b want 1 0", m0Gnt, m1Gnt);
    end
    exp0Q.push_back('{data: expMem[9], due: cyc + 1});
    nextCycle();
    idleAll();
    nextCycle();
  endtask

  initial begin
    rst = 1'b1;
    idleAll();
    for (int i = 0; i < 64; i++) expMem[i] = initWord(i);
    repeat (2) @(posedge clk);
    #1;
    test_reset();
    test_single_read();
    test_round_robin();
    test_write_then_read();
    test_lock_burst();
    test_lock_drop();
    test_reset_after_read();
    nextCycle();
    @(negedge clk);
    checks++;
    if (exp0Q.size() != 0 || exp1Q.size() != 0) begin
      failures++;
      $display("[TB] FAIL pending_reads got m0=%0d m1=%0d want 0 0", exp0Q.size(), exp1Q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
